// File: rtl/sf_tester_region_sequencer.sv
// sf_tester_region_sequencer: runs one erase / program / read-compare pass over a flash region.
// Ports: i_go/i_start_addr/i_pat_* start a pass; o_cmd_*/i_cmd_ready/i_cmd_done drive the flash
// command controller; i_tx_req/o_tx_data supply program bytes; i_rx_valid/i_rx_data return read
// bytes; o_busy/o_done/o_phase/o_err_count report progress and mismatches.
module sf_tester_region_sequencer #(
    parameter int PARM_SUBSECTOR_CNT  = 256,
    parameter int PARM_PAGE_CNT       = 4096,
    parameter int PARM_SUBSECTOR_INCR = 4096,
    parameter int PARM_PAGE_INCR      = 256,
    parameter int PARM_PAGE_BYTES     = 256
) (
    input  logic        i_clk_40mhz,
    input  logic        i_rstn_40mhz,
    input  logic        i_go,
    input  logic [31:0] i_start_addr,
    input  logic [7:0]  i_pat_start,
    input  logic [7:0]  i_pat_incr,
    output logic        o_busy,
    output logic        o_done,
    output logic [1:0]  o_phase,
    output logic [31:0] o_err_count,
    output logic        o_cmd_valid,
    output logic [1:0]  o_cmd_op,
    output logic [31:0] o_cmd_addr,
    output logic [8:0]  o_cmd_len,
    input  logic        i_cmd_ready,
    input  logic        i_cmd_done,
    input  logic        i_tx_req,
    output logic [7:0]  o_tx_data,
    input  logic        i_rx_valid,
    input  logic [7:0]  i_rx_data
);
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ER_ISSUE = 3'd1;
    localparam logic [2:0] S_ER_WAIT  = 3'd2;
    localparam logic [2:0] S_PG_ISSUE = 3'd3;
    localparam logic [2:0] S_PG_WAIT  = 3'd4;
    localparam logic [2:0] S_RD_ISSUE = 3'd5;
    localparam logic [2:0] S_RD_WAIT  = 3'd6;
    localparam logic [2:0] S_DONE     = 3'd7;
    logic [2:0]  state_q, state_d;
    logic [31:0] base_q, base_d, k_q, k_d, p_q, p_d, err_q, err_d;
    logic [7:0]  pat_q, pat_d, pat_start_q, pat_start_d, pat_incr_q, pat_incr_d;
    logic        is_er, is_pg, is_rd;
    assign is_er       = state_q == S_ER_ISSUE || state_q == S_ER_WAIT;
    assign is_pg       = state_q == S_PG_ISSUE || state_q == S_PG_WAIT;
    assign is_rd       = state_q == S_RD_ISSUE || state_q == S_RD_WAIT;
    assign o_busy      = state_q != S_IDLE;
    assign o_done      = state_q == S_DONE;
    assign o_phase     = is_er ? 2'd1 : is_pg ? 2'd2 : is_rd ? 2'd3 : 2'd0;
    assign o_cmd_valid = state_q == S_ER_ISSUE || state_q == S_PG_ISSUE || state_q == S_RD_ISSUE;
    // op encoding coincides with the phase encoding
    assign o_cmd_op    = o_cmd_valid ? o_phase : 2'd0;
    assign o_cmd_addr  = !o_cmd_valid ? 32'd0 :
                         is_er ? base_q + k_q * 32'(PARM_SUBSECTOR_INCR) :
                                 base_q + p_q * 32'(PARM_PAGE_INCR);
    assign o_cmd_len   = (o_cmd_valid && !is_er) ? 9'(PARM_PAGE_BYTES) : 9'd0;
    assign o_err_count = err_q;
    assign o_tx_data   = pat_q;
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        k_d         = k_q;
        p_d         = p_q;
        err_d       = err_q;
        pat_d       = pat_q;
        pat_start_d = pat_start_q;
        pat_incr_d  = pat_incr_q;
        case (state_q)
            S_IDLE: if (i_go) begin
                state_d     = S_ER_ISSUE;
                base_d      = i_start_addr;
                pat_start_d = i_pat_start;
                pat_incr_d  = i_pat_incr;
                err_d       = 32'd0;
                k_d         = 32'd0;
                p_d         = 32'd0;
            end
            S_ER_ISSUE: if (i_cmd_ready) state_d = S_ER_WAIT;
            S_ER_WAIT: if (i_cmd_done) begin
                k_d = k_q + 32'd1;
                if (k_d == 32'(PARM_SUBSECTOR_CNT)) begin
                    state_d = S_PG_ISSUE;
                    pat_d   = pat_start_q;
                    p_d     = 32'd0;
                end else state_d = S_ER_ISSUE;
            end
            S_PG_ISSUE: if (i_cmd_ready) state_d = S_PG_WAIT;
            S_PG_WAIT: begin
                if (i_tx_req) pat_d = pat_q + pat_incr_q;
                if (i_cmd_done) begin
                    p_d = p_q + 32'd1;
                    if (p_d == 32'(PARM_PAGE_CNT)) begin
                        state_d = S_RD_ISSUE;
                        pat_d   = pat_start_q;
                        p_d     = 32'd0;
                    end else state_d = S_PG_ISSUE;
                end
            end
            S_RD_ISSUE: if (i_cmd_ready) state_d = S_RD_WAIT;
            S_RD_WAIT: begin
                // the byte of a same-cycle rx/done pair is compared before the state moves on
                if (i_rx_valid) begin
                    if (i_rx_data != pat_q && err_q != 32'hFFFF_FFFF) err_d = err_q + 32'd1;
                    pat_d = pat_q + pat_incr_q;
                end
                if (i_cmd_done) begin
                    p_d     = p_q + 32'd1;
                    state_d = (p_d == 32'(PARM_PAGE_CNT)) ? S_DONE : S_RD_ISSUE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge i_clk_40mhz or negedge i_rstn_40mhz) begin
        if (!i_rstn_40mhz) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            k_q         <= '0;
            p_q         <= '0;
            err_q       <= '0;
            pat_q       <= '0;
            pat_start_q <= '0;
            pat_incr_q  <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            k_q         <= k_d;
            p_q         <= p_d;
            err_q       <= err_d;
            pat_q       <= pat_d;
            pat_start_q <= pat_start_d;
            pat_incr_q  <= pat_incr_d;
        end
    end
endmodule

// File: tb/tb_sf_tester_region_sequencer.sv
// tb_sf_tester_region_sequencer: vector-table and scoreboard bench for the region sequencer.
module tb_sf_tester_region_sequencer;
    localparam int SC = 2;
    localparam int PC = 2;
    localparam int PB = 4;
    logic        clk = 1'b0, rstn = 1'b0;
    logic        i_go = 1'b0, i_cmd_ready = 1'b0, i_cmd_done = 1'b0, i_tx_req = 1'b0, i_rx_valid = 1'b0;
    logic [31:0] i_start_addr = '0;
    logic [7:0]  i_pat_start = '0, i_pat_incr = '0, i_rx_data = '0;
    logic        o_busy, o_done, o_cmd_valid;
    logic [1:0]  o_phase, o_cmd_op;
    logic [31:0] o_err_count, o_cmd_addr;
    logic [8:0]  o_cmd_len;
    logic [7:0]  o_tx_data;
    always #12 clk = ~clk;
    sf_tester_region_sequencer #(
        .PARM_SUBSECTOR_CNT(SC), .PARM_PAGE_CNT(PC), .PARM_PAGE_BYTES(PB)
    ) dut (
        .i_clk_40mhz(clk), .i_rstn_40mhz(rstn), .i_go(i_go), .i_start_addr(i_start_addr),
        .i_pat_start(i_pat_start), .i_pat_incr(i_pat_incr), .o_busy(o_busy), .o_done(o_done),
        .o_phase(o_phase), .o_err_count(o_err_count), .o_cmd_valid(o_cmd_valid),
        .o_cmd_op(o_cmd_op), .o_cmd_addr(o_cmd_addr), .o_cmd_len(o_cmd_len),
        .i_cmd_ready(i_cmd_ready), .i_cmd_done(i_cmd_done), .i_tx_req(i_tx_req),
        .o_tx_data(o_tx_data), .i_rx_valid(i_rx_valid), .i_rx_data(i_rx_data)
    );
    typedef struct {
        logic [31:0] addr;
        logic [7:0]  ps, pi, mask, bad;
        int          rdly;
        bit          stray, rego;
        logic [31:0] err;
    } vec_t;
    typedef struct {
        logic [1:0]  op;
        logic [31:0] addr;
        logic [8:0]  len;
    } cmd_t;
    vec_t vecs[5];
    cmd_t cq[$];
    logic [7:0] txq[$];
    logic [7:0] rxq[$];
    int tests = 0, fails = 0, done_cnt = 0, rxi = 0;
    always @(negedge clk) if (o_done) done_cnt++;
    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic summary();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    endtask
    task automatic push_iter(input vec_t v);
        logic [7:0] b;
        for (int k = 0; k < SC; k++) cq.push_back('{2'd1, v.addr + 32'(k) * 32'd4096, 9'd0});
        for (int p = 0; p < PC; p++) cq.push_back('{2'd2, v.addr + 32'(p) * 32'd256, 9'(PB)});
        for (int p = 0; p < PC; p++) cq.push_back('{2'd3, v.addr + 32'(p) * 32'd256, 9'(PB)});
        b = v.ps;
        for (int i = 0; i < PC * PB; i++) begin
            txq.push_back(b);
            rxq.push_back(b);
            b = b + v.pi;
        end
    endtask
    task automatic pulse_done();
        @(negedge clk);
        @(negedge clk);
        i_cmd_done = 1'b1;
        @(negedge clk);
        i_cmd_done = 1'b0;
    endtask
    task automatic accept(input vec_t v, output cmd_t e);
        cmd_t a;
        int t = 0;
        bit stable = 1'b1;
        while (!o_cmd_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!o_cmd_valid) begin
            chk("cmd_valid_timeout", 32'(o_cmd_valid), 32'd1);
            summary();
        end
        a = '{o_cmd_op, o_cmd_addr, o_cmd_len};
        for (int i = 1; i < v.rdly; i++) begin
            @(negedge clk);
            if (!o_cmd_valid || o_cmd_op != a.op || o_cmd_addr != a.addr || o_cmd_len != a.len) stable = 1'b0;
        end
        if (v.rdly > 1) chk("cmd_hold_stable", 32'(stable), 32'd1);
        i_cmd_ready = 1'b1;
        i_cmd_done  = v.stray;
        @(negedge clk);
        i_cmd_ready = 1'b0;
        i_cmd_done  = 1'b0;
        e = cq.pop_front();
        chk("cmd_op", 32'(a.op), 32'(e.op));
        chk("cmd_addr", a.addr, e.addr);
        chk("cmd_len", 32'(a.len), 32'(e.len));
        chk("valid_drop", 32'(o_cmd_valid), 32'd0);
        chk("phase", 32'(o_phase), 32'(e.op));
    endtask
    task automatic serve_cmd(input vec_t v, input bit last);
        cmd_t e;
        logic [7:0] x;
        accept(v, e);
        if (e.op == 2'd1) pulse_done();
        else if (e.op == 2'd2) begin
            for (int i = 0; i < PB; i++) begin
                i_tx_req = 1'b1;
                chk("tx_data", 32'(o_tx_data), 32'(txq.pop_front()));
                @(negedge clk);
            end
            i_tx_req = 1'b0;
            if (v.rego) begin
                i_go = 1'b1;
                i_start_addr = 32'hDEAD_0000;
                i_pat_start = 8'h55;
                @(negedge clk);
                i_go = 1'b0;
                i_start_addr = v.addr;
                i_pat_start = v.ps;
                chk("rego_phase", 32'(o_phase), 32'd2);
            end
            pulse_done();
        end else begin
            for (int i = 0; i < PB; i++) begin
                x = rxq.pop_front();
                i_rx_valid = 1'b1;
                i_rx_data = v.mask[rxi] ? v.bad : x;
                rxi++;
                if (last && i == PB - 1) i_cmd_done = 1'b1;
                @(negedge clk);
            end
            i_rx_valid = 1'b0;
            i_cmd_done = 1'b0;
            if (!last) pulse_done();
        end
    endtask
    task automatic run_iter(input vec_t v);
        int d0;
        i_start_addr = v.addr;
        i_pat_start = v.ps;
        i_pat_incr = v.pi;
        i_go = 1'b1;
        push_iter(v);
        d0 = done_cnt;
        rxi = 0;
        @(negedge clk);
        i_go = 1'b0;
        chk("go_latency_valid", 32'(o_cmd_valid), 32'd1);
        chk("busy", 32'(o_busy), 32'd1);
        for (int c = 0; c < 3 * PC; c++) serve_cmd(v, c == 3 * PC - 1);
        chk("done_pulse", 32'(o_done), 32'd1);
        @(negedge clk);
        chk("done_once", 32'(done_cnt - d0), 32'd1);
        chk("done_low", 32'(o_done), 32'd0);
        chk("idle_busy", 32'(o_busy), 32'd0);
        chk("err_count", o_err_count, v.err);
        i_cmd_done = 1'b1;
        @(negedge clk);
        i_cmd_done = 1'b0;
        @(negedge clk);
        chk("stray_done_idle", {30'd0, o_busy, o_cmd_valid}, 32'd0);
    endtask
    initial begin
        cmd_t e;
        int d0;
        vecs[0] = '{32'h0010_0000, 8'h08, 8'h07, 8'h00, 8'h00, 1,  1'b0, 1'b0, 32'd0};
        vecs[1] = '{32'h0010_0000, 8'h08, 8'h07, 8'h04, 8'h00, 1,  1'b0, 1'b0, 32'd1};
        vecs[2] = '{32'h0020_0000, 8'hF8, 8'h17, 8'h00, 8'h00, 1,  1'b0, 1'b0, 32'd0};
        vecs[3] = '{32'hFFFF_F000, 8'h11, 8'h01, 8'h00, 8'h00, 10, 1'b1, 1'b0, 32'd0};
        vecs[4] = '{32'h1234_5600, 8'h01, 8'h01, 8'hFF, 8'h00, 1,  1'b0, 1'b1, 32'd8};
        repeat (2) @(negedge clk);
        chk("reset_outs", {8'd0, o_busy, o_done, o_phase, o_cmd_valid, o_cmd_op, o_cmd_len, o_tx_data}, 32'd0);
        chk("reset_err", o_err_count, 32'd0);
        chk("reset_addr", o_cmd_addr, 32'd0);
        rstn = 1'b1;
        @(negedge clk);
        for (int n = 0; n < 5; n++) run_iter(vecs[n]);
        i_start_addr = vecs[0].addr;
        i_pat_start = vecs[0].ps;
        i_pat_incr = vecs[0].pi;
        i_go = 1'b1;
        push_iter(vecs[0]);
        rxi = 0;
        @(negedge clk);
        i_go = 1'b0;
        for (int c = 0; c < 2 * PC; c++) serve_cmd(vecs[0], 1'b0);
        accept(vecs[0], e);
        i_rx_valid = 1'b1;
        i_rx_data = ~rxq.pop_front();
        @(negedge clk);
        i_rx_valid = 1'b0;
        chk("pre_reset_err", o_err_count, 32'd1);
        d0 = done_cnt;
        #2 rstn = 1'b0;
        #1;
        chk("async_reset_outs", {8'd0, o_busy, o_done, o_phase, o_cmd_valid, o_cmd_op, o_cmd_len, o_tx_data}, 32'd0);
        chk("async_reset_err", o_err_count, 32'd0);
        chk("async_reset_addr", o_cmd_addr, 32'd0);
        cq.delete();
        txq.delete();
        rxq.delete();
        repeat (3) @(negedge clk);
        chk("reset_no_done", 32'(done_cnt - d0), 32'd0);
        rstn = 1'b1;
        @(negedge clk);
        run_iter(vecs[0]);
        summary();
    end
endmodule

// File: doc/sf_tester_region_sequencer.md
Name: sf_tester_region_sequencer

Overview:
- Sequences one test iteration of the serial-flash tester over a 1 MiB region: erase all subsectors, program all pages with an arithmetic byte pattern, then read back and compare.
- Sits between the tester top FSM, which supplies start address and pattern and pulses go, and the flash command controller, which executes erase, page-program and read commands.
- Counts byte mismatches.

Parameters:
PARM_SUBSECTOR_CNT, 256, erase commands per iteration
PARM_PAGE_CNT, 4096, program and read commands per iteration
PARM_SUBSECTOR_INCR, 4096, address step between erase commands
PARM_PAGE_INCR, 256, address step between page commands
PARM_PAGE_BYTES, 256, bytes per program or read command (1..256)

Ports:
i_clk_40mhz  in  1  system clock
i_rstn_40mhz  in  1  asynchronous active-low reset
i_go  in  1  start pulse; accepted only in IDLE
i_start_addr  in  32  region base byte address
i_pat_start  in  8  first pattern byte
i_pat_incr  in  8  pattern increment per byte
o_busy  out  1  high in every state except IDLE
o_done  out  1  one-cycle pulse at iteration end
o_phase  out  2  0 idle/done, 1 erase, 2 program, 3 read
o_err_count  out  32  mismatched read bytes, saturating
o_cmd_valid  out  1  command request
o_cmd_op  out  2  1 erase subsector, 2 page program, 3 read
o_cmd_addr  out  32  command byte address
o_cmd_len  out  9  byte count; 0 for erase
i_cmd_ready  in  1  controller accepts the command when high with o_cmd_valid
i_cmd_done  in  1  one-cycle pulse when the accepted command completes
i_tx_req  in  1  controller consumes o_tx_data this cycle
o_tx_data  out  8  current program byte
i_rx_valid  in  1  read byte strobe
i_rx_data  in  8  read byte

Behaviour:
Reset:
- All outputs 0; o_tx_data = 0; state IDLE.
- Reset mid-operation abandons the command immediately; no o_done pulse.
Registers:
- On accepted i_go, latch start_addr, pat_start and pat_incr; clear o_err_count and the sub-counters.
- i_go while busy is ignored.
State machine:
- IDLE: on i_go go to ER_ISSUE next cycle, so o_cmd_valid is high 1 cycle after i_go.
- ER_ISSUE: o_cmd_valid=1, op=1, addr=base+k*PARM_SUBSECTOR_INCR, len=0. op, addr and len stay stable until ready. On i_cmd_ready go to ER_WAIT and drop valid next cycle.
- ER_WAIT: on i_cmd_done, k++. If k==PARM_SUBSECTOR_CNT, go to PG_ISSUE with the pattern register = pat_start and page index p=0. Else go to ER_ISSUE.
- PG_ISSUE: op=2, addr=base+p*PARM_PAGE_INCR, len=PARM_PAGE_BYTES; handshake as for erase, then go to PG_WAIT.
- PG_WAIT: on i_tx_req, the pattern register is updated to pattern+pat_incr (mod 256) at the clock edge. The pattern does not restart per page.
- PG_WAIT, on i_cmd_done: p++. If p==PARM_PAGE_CNT, reload pattern=pat_start, set p=0 and go to RD_ISSUE. Else go to PG_ISSUE.
- RD_ISSUE and RD_WAIT: op=3, same addressing as program.
- RD_WAIT, on i_rx_valid: compare i_rx_data with the expected byte; increment o_err_count on mismatch, saturating at 0xFFFFFFFF. Advance expected by pat_incr.
- RD_WAIT, on i_cmd_done: p++. If p==PARM_PAGE_CNT go to DONE, else go to RD_ISSUE.
- DONE: o_done=1 for one cycle, then IDLE.
Outputs and arithmetic:
- o_tx_data continuously reflects the pattern register.
- o_phase: 1 in ER_*, 2 in PG_*, 3 in RD_*, 0 otherwise.
- Address arithmetic is 32-bit modulo; wrap past 0xFFFFFFFF is silent.
Boundaries:
- i_cmd_done is sampled only in *_WAIT states and ignored elsewhere, including the acceptance cycle.
- i_tx_req outside PG_WAIT and i_rx_valid outside RD_WAIT are ignored.
- Extra rx bytes beyond PARM_PAGE_BYTES in one read are still compared. The bytes-per-page count is not policed.
- i_rx_valid and i_cmd_done in the same cycle: the byte is compared first, then the state advances.

Test Plan:
Bench params: PARM_SUBSECTOR_CNT=2, PARM_PAGE_CNT=2, PARM_PAGE_BYTES=4; responder model acks ready after 1 cycle and pulses done after 3 cycles.
1. Full iteration
- Stimulus: go with addr=0x00100000, start=0x08, incr=0x07; model returns exact data.
- Commands: erase at 0x00100000 and 0x00101000; program at 0x00100000 and 0x00100100; reads at the same page addresses.
- Tx bytes: 08, 0F, 16, 1D, 24, 2B, 32, 39.
- Result: o_err_count=0, one o_done pulse.
2. Corrupted readback: the model flips the 3rd read byte to 0x00 -> o_err_count=1.
3. Wrap: start=0xF8, incr=0x17 -> 5th tx byte = 0xF8+4*0x17 mod 256 = 0x54.
4. Ready back-pressure
- Stimulus: hold i_cmd_ready low 10 cycles on each command.
- Required: o_cmd_valid/op/addr/len stable throughout; one command accepted per ready.
5. Re-go and stray done
- Stimulus: i_go pulsed during PG_WAIT; stray i_cmd_done pulsed in IDLE.
- Required: no effect; no restart.
6. Reset mid-run
- Stimulus: assert i_rstn_40mhz low in RD_WAIT.
- Required: all outputs 0 immediately with no clock edge; no o_done; a fresh go restarts from erase.
